bcd_to_dec_decoder: RTL and testbench
=====================================

# bcd_to_dec_decoder

Sequential BCD-to-decimal decoder, the inverse of the team's decimal-to-BCD encoder. It accepts a packed multi-digit BCD word over a valid/ready handshake. It then emits the digits one per handshake as 10-bit one-hot decimal codes (bit n set means digit n), flagging and counting non-BCD nibbles. It sits between numeric datapath blocks and one-hot consumers such as display and segment drivers.

## Interface
- `DIGITS`, default 4: BCD digits per input word; legal range 2–8.
- `MSD_FIRST`, default 1: 1 emits the most-significant digit first; 0 emits the least-significant digit first.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset is synchronous and active-high.
- `in_valid` input 1: input word valid.
- `in_ready` output 1: block can accept a word.
- `in_bcd` input 4*DIGITS: packed BCD word; digit k occupies bits [4k+3:4k], with digit 0 least significant.
- `out_valid` output 1: a decoded digit is presented.
- `out_ready` input 1: consumer accepts the digit.
- `out_dec` output 10: one-hot decimal code for the current digit.
- `out_idx` output clog2(DIGITS): position k of the current digit.
- `out_last` output 1: current digit is the final digit of the word.
- `out_err` output 1: current nibble is 10–15.
- `err_count` output 8: saturating count of error digits handed off.

## Operation
- FSM states are IDLE and EMIT.
- **IDLE**
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`&&`in_ready`, register `in_bcd` and set the digit counter to the first position: DIGITS-1 if `MSD_FIRST`, else 0.
  - Then go to EMIT.
- **EMIT**
  - `in_ready`=0 and `out_valid`=1.
  - `out_dec`, `out_err`, `out_idx` and `out_last` all reflect the nibble at the counter position.
  - On `out_valid`&&`out_ready`:
    - If `out_last`, go to IDLE.
    - Otherwise step the counter: decrement if `MSD_FIRST`, else increment.
- **Decode rule**
  - Nibble n in 0–9 gives `out_dec` = 1<<n and `out_err`=0.
  - Nibble 10–15 gives `out_dec` = 0 and `out_err`=1.
- `err_count` increments by 1 on every handshake where `out_err`=1, and holds at 255.
- `in_valid` asserted in EMIT is ignored; the word is not captured.
- Outputs depend only on registered state. There is no combinational path from `in_*` or `out_ready` to any output.

## Timing
- **Reset values** (while `rst`=1 and on the cycle after it falls, until the first transfer): state IDLE, `in_ready`=0 during `rst`, `out_valid`=0, `out_dec`=0, `out_idx`=0, `out_last`=0, `out_err`=0, `err_count`=0.
- `in_ready` rises the first cycle `rst` is low.
- **Latency:** a word accepted at edge t produces `out_valid`=1 from edge t (visible in cycle t+1).
- **Throughput:** with `out_ready` held at 1, one word takes DIGITS+1 cycles, i.e. DIGITS output cycles plus one IDLE cycle. There is no same-cycle accept on the last handshake.
- **Backpressure:** while `out_valid`=1 and `out_ready`=0, `out_dec`, `out_idx`, `out_last` and `out_err` hold stable.
- **Reset mid-word:** the captured word is discarded, the state returns to IDLE, and `err_count` clears. No partial digits are emitted after reset.
- The counter never wraps: `out_last` is asserted exactly once per word, at position 0 (`MSD_FIRST`=1) or DIGITS-1 (`MSD_FIRST`=0).

## Structure
- Package `bcd_pkg` holds:
  - `BCD_W`=4 and `DEC_W`=10.
  - The FSM state enum {IDLE, EMIT}.
  - `ERR_CNT_W`=8.
- Sub-module `bcd_digit_decoder` is purely combinational: 4-bit nibble in, `dec[9:0]` and `err` out. It is instantiated once on the selected nibble.
- The top level contains the FSM, word register, digit counter, and error counter.

## Test plan
- **Reset:** assert `rst` for 3 cycles with `in_valid`=1 → all outputs zero, `in_ready`=0; after release `in_ready`=1 and nothing is captured during reset.
- **MSD-first word:** DIGITS=4, `in_bcd`=16'h1937, `out_ready`=1 → the following sequence, then `in_ready`=1 on the following cycle:
  - `out_dec` 0x002, 0x200, 0x008, 0x080
  - `out_idx` 3, 2, 1, 0
  - `out_last` only on the 4th digit
- **LSD-first word:** `MSD_FIRST`=0 with the same word → `out_dec` 0x080, 0x008, 0x200, 0x002 and `out_idx` 0, 1, 2, 3.
- **Backpressure:** on 16'h0420, hold `out_ready`=0 for 5 cycles on the 2nd digit → `out_dec`=0x010 and `out_idx`=2 stay stable; `in_valid` pulses meanwhile are ignored.
- **Invalid nibbles:**
  - 16'hA5F0 → `out_err` pattern 1, 0, 1, 0, `out_dec` 0, 0x020, 0, 0x001, and `err_count`=2.
  - 130 words of 16'hFFFF → `err_count` saturates at 255.
- **Reset mid-word:** assert `rst` after the 2nd digit of 16'h1234 → `out_valid`=0 next cycle, `err_count`=0; the next word 16'h5678 emits from its first digit (0x020).

Source files
------------

// File: rtl/bcd_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared widths and FSM state type for the BCD-to-decimal decoder.
//   BCD_W     : bits per BCD digit
//   DEC_W     : width of the one-hot decimal code
//   ERR_CNT_W : width of the saturating error-digit counter
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int BCD_W     = 4;
    localparam int DEC_W     = 10;
    localparam int ERR_CNT_W = 8;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

endpackage : bcd_pkg

// File: rtl/bcd_digit_decoder.sv
// ---------------------------------------------------------------------------
// bcd_digit_decoder
// Purely combinational decode of one BCD nibble into a one-hot decimal code.
// Ports:
//   nibble_i : 4-bit BCD digit
//   dec_o    : one-hot code, bit n set for digit n; all zero for 10..15
//   err_o    : high when the nibble is not a legal BCD digit (10..15)
// ---------------------------------------------------------------------------
module bcd_digit_decoder
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] nibble_i,
    output logic [DEC_W-1:0] dec_o,
    output logic             err_o
);

    always_comb begin
        dec_o = '0;
        err_o = 1'b0;
        if (nibble_i <= BCD_W'(9)) begin
            dec_o = DEC_W'(1) << nibble_i;
        end else begin
            err_o = 1'b1;
        end
    end

endmodule : bcd_digit_decoder

// File: rtl/bcd_to_dec_decoder.sv
// ---------------------------------------------------------------------------
// bcd_to_dec_decoder
// Accepts a packed multi-digit BCD word over valid/ready and emits its digits
// one per handshake as one-hot decimal codes, flagging and counting nibbles
// that are not legal BCD.
// Parameters:
//   DIGITS    : BCD digits per word (2..8)
//   MSD_FIRST : 1 = most-significant digit first, 0 = least-significant first
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  / in_ready  / in_bcd  : input word handshake, digit k at [4k+3:4k]
//   out_valid / out_ready           : output digit handshake
//   out_dec   : one-hot decimal code of the current digit
//   out_idx   : position of the current digit within the word
//   out_last  : current digit is the final one of the word
//   out_err   : current nibble is 10..15
//   err_count : saturating count of error digits handed off
// ---------------------------------------------------------------------------
module bcd_to_dec_decoder
    import bcd_pkg::*;
#(
    parameter int DIGITS    = 4,
    parameter bit MSD_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BCD_W*DIGITS-1:0]   in_bcd,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DEC_W-1:0]          out_dec,
    output logic [$clog2(DIGITS)-1:0] out_idx,
    output logic                      out_last,
    output logic                      out_err,
    output logic [ERR_CNT_W-1:0]      err_count
);

    localparam int IDX_W = $clog2(DIGITS);

    // Traversal endpoints: the counter starts at FIRST_IDX and the word ends
    // at LAST_IDX, so the counter never needs to wrap.
    localparam logic [IDX_W-1:0] FIRST_IDX = MSD_FIRST ? IDX_W'(DIGITS - 1) : '0;
    localparam logic [IDX_W-1:0] LAST_IDX  = MSD_FIRST ? '0 : IDX_W'(DIGITS - 1);

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_e                    state_q, state_d;
    logic [BCD_W*DIGITS-1:0]   word_q, word_d;
    logic [IDX_W-1:0]          cnt_q, cnt_d;
    logic [ERR_CNT_W-1:0]      err_cnt_q, err_cnt_d;

    logic [BCD_W-1:0]          digit_a [DIGITS];
    logic [BCD_W-1:0]          nibble;
    logic [DEC_W-1:0]          dig_dec;
    logic                      dig_err;
    logic                      emit;
    logic                      at_last;

    // Unpack the captured word so the counter can index a digit directly.
    always_comb begin
        for (int k = 0; k < DIGITS; k++) begin
            digit_a[k] = word_q[k*BCD_W +: BCD_W];
        end
        nibble = digit_a[cnt_q];
    end

    bcd_digit_decoder u_digit (
        .nibble_i (nibble),
        .dec_o    (dig_dec),
        .err_o    (dig_err)
    );

    assign emit    = (state_q == EMIT);
    assign at_last = (cnt_q == LAST_IDX);

    // Digit outputs are forced to zero outside EMIT so a stale word or
    // counter left over from the previous transfer is never visible.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = emit;
    assign out_dec   = emit ? dig_dec : '0;
    assign out_err   = emit ? dig_err : 1'b0;
    assign out_idx   = emit ? cnt_q   : '0;
    assign out_last  = emit ? at_last : 1'b0;
    assign err_count = err_cnt_q;

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        cnt_d     = cnt_q;
        err_cnt_d = err_cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d  = in_bcd;
                    cnt_d   = FIRST_IDX;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                // in_valid is deliberately not looked at here: a word offered
                // while digits are still being emitted is not captured.
                if (out_ready) begin
                    if (dig_err) begin
                        err_cnt_d = sat_inc(err_cnt_q);
                    end
                    if (at_last) begin
                        state_d = IDLE;
                    end else if (MSD_FIRST) begin
                        cnt_d = cnt_q - 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Data register: only observed while in EMIT, so it needs no reset.
    always_ff @(posedge clk) begin
        word_q <= word_d;
    end

endmodule : bcd_to_dec_decoder

// File: tb/tb_bcd_to_dec_decoder.sv
module tb_bcd_to_dec_decoder;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    typedef struct packed {
        logic [9:0] dec;
        logic [1:0] idx;
        logic       last;
        logic       err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_bcd = '0;
    bit           rand_bp = 1'b0;

    // index 0: MSD-first instance, index 1: LSD-first instance
    logic       in_ready_w  [2];
    logic       out_valid_w [2];
    logic [9:0] out_dec_w   [2];
    logic [1:0] out_idx_w   [2];
    logic       out_last_w  [2];
    logic       out_err_w   [2];
    logic [7:0] err_count_w [2];

    exp_t sbq [2][$];
    int   exp_errc [2];
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;

    bcd_to_dec_decoder #(.DIGITS(DIGITS), .MSD_FIRST(1'b1)) u_msd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[0]),
        .in_bcd(in_bcd), .out_valid(out_valid_w[0]), .out_ready(out_ready),
        .out_dec(out_dec_w[0]), .out_idx(out_idx_w[0]), .out_last(out_last_w[0]),
        .out_err(out_err_w[0]), .err_count(err_count_w[0])
    );

    bcd_to_dec_decoder #(.DIGITS(DIGITS), .MSD_FIRST(1'b0)) u_lsd (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w[1]),
        .in_bcd(in_bcd), .out_valid(out_valid_w[1]), .out_ready(out_ready),
        .out_dec(out_dec_w[1]), .out_idx(out_idx_w[1]), .out_last(out_last_w[1]),
        .out_err(out_err_w[1]), .err_count(err_count_w[1])
    );

    task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s[%0d] t=%0t: got 0x%0h expected 0x%0h", nm, i, $time, act, exp);
        end
    endtask

    // Reference model: split the word into decimal digits with plain
    // arithmetic and list them in emission order for each instance.
    task automatic push_word(input logic [W-1:0] w);
        exp_t e;
        int   k;
        int   v;
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < DIGITS; n++) begin
                k = (s == 0) ? (DIGITS - 1 - n) : n;
                v = (int'(w) >> (4 * k)) % 16;
                e.dec  = (v < 10) ? 10'(1 << v) : 10'd0;
                e.idx  = k[1:0];
                e.last = (n == DIGITS - 1);
                e.err  = (v > 9);
                sbq[s].push_back(e);
            end
        end
    endtask

    task automatic send(input logic [W-1:0] w);
        bit ok;
        ok = 1'b0;
        in_bcd   = w;
        in_valid = 1'b1;
        for (int c = 0; c < 300 && !ok; c++) begin
            @(negedge clk);
            ok = in_ready_w[0];
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (ok) push_word(w);
        else chk("accept_timeout", 0, 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && c < 1000) begin
            @(posedge clk);
            #1;
            c++;
        end
        chk("drain_pending", 0, 32'(sbq[0].size() + sbq[1].size()), 32'd0);
    endtask

    // Random backpressure driver, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: compares every presented digit with the head of its queue and
    // pops on each handshake; also tracks the expected error count.
    initial begin
        logic rst_prev;
        rst_prev = 1'b0;
        exp_errc[0] = 0;
        exp_errc[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    chk("in_ready_in_reset", i, 32'(in_ready_w[i]), 32'd0);
                    if (rst_prev) begin
                        chk("reset_outputs", i,
                            32'({in_ready_w[i], out_valid_w[i], out_dec_w[i], out_idx_w[i],
                                 out_last_w[i], out_err_w[i], err_count_w[i]}), 32'd0);
                    end
                    exp_errc[i] = 0;
                end else begin
                    chk("err_count", i, 32'(err_count_w[i]), 32'(exp_errc[i]));
                    if (out_valid_w[i]) begin
                        if (sbq[i].size() == 0) begin
                            chk("unexpected_digit", i, 32'd1, 32'd0);
                        end else begin
                            chk("digit{dec,idx,last,err}", i,
                                32'({out_dec_w[i], out_idx_w[i], out_last_w[i], out_err_w[i]}),
                                32'(sbq[i][0]));
                            if (out_ready) begin
                                if (sbq[i][0].err && exp_errc[i] < 255) exp_errc[i]++;
                                void'(sbq[i].pop_front());
                            end
                        end
                    end else begin
                        chk("idle{rdy,dec,idx,last,err}", i,
                            32'({in_ready_w[i], out_dec_w[i], out_idx_w[i], out_last_w[i], out_err_w[i]}),
                            32'({1'b1, 10'd0, 2'd0, 1'b0, 1'b0}));
                    end
                end
            end
            rst_prev = rst;
        end
    end

    initial begin
        int n;
        logic [W-1:0] w;

        // Reset with in_valid held high: nothing may be captured.
        rst      = 1'b1;
        in_valid = 1'b1;
        in_bcd   = W'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rdy_after_reset", i, 32'(in_ready_w[i]), 32'd1);
            chk("no_capture_in_reset", i, 32'(out_valid_w[i]), 32'd0);
        end
        @(posedge clk);
        #1;

        // MSD/LSD-first word with a throughput check.
        out_ready = 1'b1;
        send(16'h1937);
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (in_ready_w[0]) break;
            n++;
            @(posedge clk);
            #1;
        end
        chk("busy_cycles", 0, 32'(n), 32'(DIGITS));
        chk("lsd_ready_back", 1, 32'(in_ready_w[1]), 32'd1);
        @(posedge clk);
        #1;

        // Backpressure on the second digit with ignored in_valid pulses.
        send(16'h0420);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
            in_valid = 1'($urandom_range(0, 1));
            in_bcd   = W'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        // Invalid nibbles.
        send(16'hA5F0);
        wait_idle();
        @(negedge clk);
        chk("err_count_A5F0", 0, 32'(err_count_w[0]), 32'd2);
        chk("err_count_A5F0", 1, 32'(err_count_w[1]), 32'd2);
        @(posedge clk);
        #1;

        repeat (130) send(16'hFFFF);
        wait_idle();
        @(negedge clk);
        chk("err_count_sat", 0, 32'(err_count_w[0]), 32'd255);
        chk("err_count_sat", 1, 32'(err_count_w[1]), 32'd255);
        @(posedge clk);
        #1;

        // Reset in the middle of a word.
        send(16'h1234);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        sbq[0].delete();
        sbq[1].delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("valid_after_midreset", i, 32'(out_valid_w[i]), 32'd0);
            chk("errcnt_after_midreset", i, 32'(err_count_w[i]), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(16'h5678);
        wait_idle();

        // Random words, random gaps and random backpressure.
        rand_bp = 1'b1;
        for (int t = 0; t < 60; t++) begin
            for (int d = 0; d < DIGITS; d++) begin
                w[4*d +: 4] = 4'($urandom_range(0, 11));
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send(w);
        end
        wait_idle();
        rand_bp   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_bcd_to_dec_decoder
